// File: rtl/gs_pkg.sv
// Shared constants, FSM state type and helpers for the minifloat Goldschmidt sequencer.
// Minifloat format: {sign[7], exp[6:3] bias 7, frac[2:0] with hidden 1}.
package gs_pkg;

    localparam int SIGN_BIT = 7;
    localparam int EXP_MSB  = 6;
    localparam int EXP_LSB  = 3;
    localparam int FRAC_W   = 3;

    localparam logic [7:0] ONE_VAL      = 8'h38;
    localparam logic [6:0] MAX_FRAC_VAL = 7'h7F;

    // Denominator values treated as "close enough" to 1.0
    localparam logic [7:0] CVG_VAL_0 = 8'h38;
    localparam logic [7:0] CVG_VAL_1 = 8'h37;
    localparam logic [7:0] CVG_VAL_2 = 8'h36;
    localparam logic [7:0] CVG_VAL_3 = 8'h34;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } gs_state_e;

    function automatic logic is_converged(input logic [7:0] c);
        return (c == CVG_VAL_0) || (c == CVG_VAL_1) ||
               (c == CVG_VAL_2) || (c == CVG_VAL_3);
    endfunction

endpackage

// File: rtl/gs_seed_rom.sv
// Reciprocal seed exponent lookup for the Goldschmidt divider.
// Exponents outside the table return 4'b0000, which the sequencer treats as a range error.
module gs_seed_rom
    import gs_pkg::*;
(
    input  logic [3:0] i_exp,
    output logic [3:0] o_seed
);

    // Seed exponent roughly mirrors the divisor exponent around the bias.
    always_comb begin
        o_seed = 4'b0000;
        case (i_exp)
            4'b0111: o_seed = 4'b0111;
            4'b1000: o_seed = 4'b0110;
            4'b1001: o_seed = 4'b0101;
            4'b1010: o_seed = 4'b0100;
            4'b0110: o_seed = 4'b1000;
            4'b0101: o_seed = 4'b1001;
            4'b0100: o_seed = 4'b1010;
            default: o_seed = 4'b0000;
        endcase
    end

endmodule

// File: rtl/gs_iter_seq.sv
// Sequential Goldschmidt divider controller reusing one combinational iteration stage.
// Build option GS_EARLY_EXIT_EN: when defined, exits as soon as the denominator converges.
module gs_iter_seq
    import gs_pkg::*;
#(
    parameter int MAX_ITER = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_a,
    input  logic [7:0] in_b,
    output logic [7:0] it_a,
    output logic [7:0] it_b,
    output logic [7:0] it_xi,
    input  logic [7:0] it_c,
    input  logic [7:0] it_d,
    input  logic [7:0] it_xinew,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_q,
    output logic [2:0] out_iters,
    output logic       out_cvg,
    output logic       out_dz,
    output logic       out_rng
);

    localparam logic [2:0] MAX_ITER_C = 3'(MAX_ITER);

    gs_state_e  r_state;
    logic [2:0] r_cnt;
    logic       r_in_ready;
    logic       r_out_valid;
    logic [7:0] r_out_q;
    logic [2:0] r_out_iters;
    logic       r_out_cvg;
    logic       r_out_dz;
    logic       r_out_rng;
    logic [7:0] r_it_a;
    logic [7:0] r_it_b;
    logic [7:0] r_it_xi;

    logic [3:0] w_seed;
    logic [2:0] w_next_cnt;
    logic       w_cvg;
    logic       w_exit;
    logic       w_accept;

    gs_seed_rom u_seed_rom (
        .i_exp  (in_b[EXP_MSB:EXP_LSB]),
        .o_seed (w_seed)
    );

    assign w_accept   = in_valid && r_in_ready;
    assign w_next_cnt = r_cnt + 3'd1;
    assign w_cvg      = is_converged(it_c);

`ifdef GS_EARLY_EXIT_EN
    assign w_exit = w_cvg || (w_next_cnt == MAX_ITER_C);
`else
    assign w_exit = (w_next_cnt == MAX_ITER_C);
`endif

    // Controller FSM: accept, iterate through the stage, hold result until consumed.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= 3'd0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_q     <= 8'h00;
            r_out_iters <= 3'd0;
            r_out_cvg   <= 1'b0;
            r_out_dz    <= 1'b0;
            r_out_rng   <= 1'b0;
            r_it_a      <= 8'h00;
            r_it_b      <= 8'h00;
            r_it_xi     <= 8'h00;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_in_ready <= 1'b0;
                        r_out_cvg  <= 1'b0;
                        r_out_dz   <= 1'b0;
                        r_out_rng  <= 1'b0;
                        if (in_b == 8'h00) begin
                            r_out_q     <= {in_a[SIGN_BIT] ^ in_b[SIGN_BIT], MAX_FRAC_VAL};
                            r_out_dz    <= 1'b1;
                            r_out_iters <= 3'd0;
                            r_out_valid <= 1'b1;
                            r_state     <= DONE;
                        end else if (in_a == 8'h00) begin
                            r_out_q     <= 8'h00;
                            r_out_iters <= 3'd0;
                            r_out_valid <= 1'b1;
                            r_state     <= DONE;
                        end else if (w_seed == 4'b0000) begin
                            r_out_q     <= 8'h00;
                            r_out_rng   <= 1'b1;
                            r_out_iters <= 3'd0;
                            r_out_valid <= 1'b1;
                            r_state     <= DONE;
                        end else begin
                            // Stage inputs only move on a real division so specials leave them intact.
                            r_it_a  <= in_a;
                            r_it_b  <= in_b;
                            r_it_xi <= {1'b0, w_seed, {FRAC_W{1'b0}}};
                            r_cnt   <= 3'd0;
                            r_state <= ITER;
                        end
                    end
                end
                ITER: begin
                    r_cnt <= w_next_cnt;
                    if (w_exit) begin
                        r_out_q     <= it_d;
                        r_out_iters <= w_next_cnt;
                        r_out_cvg   <= w_cvg;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end else begin
                        r_it_xi <= it_xinew;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_q     = r_out_q;
    assign out_iters = r_out_iters;
    assign out_cvg   = r_out_cvg;
    assign out_dz    = r_out_dz;
    assign out_rng   = r_out_rng;
    assign it_a      = r_it_a;
    assign it_b      = r_it_b;
    assign it_xi     = r_it_xi;

endmodule

// File: tb/tb_gs_iter_seq.sv
// Self-checking bench for gs_iter_seq: directed table, hand sequences, and randomized
// operations checked against a loop-based reference model driving a stand-in iteration stage.
module tb_gs_iter_seq;

    localparam int MAXI = 3;
`ifdef GS_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_a = 8'h00;
    logic [7:0] in_b = 8'h00;
    logic [7:0] it_a, it_b, it_xi;
    logic [7:0] it_c, it_d, it_xinew;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_q;
    logic [2:0] out_iters;
    logic       out_cvg, out_dz, out_rng;

    int checks = 0;
    int errors = 0;
    int stage_mode = 0;
    logic [7:0] g_ita = 8'h00, g_itb = 8'h00, g_itxi = 8'h00;

    gs_iter_seq #(.MAX_ITER(MAXI)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .it_a(it_a), .it_b(it_b), .it_xi(it_xi),
        .it_c(it_c), .it_d(it_d), .it_xinew(it_xinew),
        .out_valid(out_valid), .out_ready(out_ready), .out_q(out_q),
        .out_iters(out_iters), .out_cvg(out_cvg), .out_dz(out_dz), .out_rng(out_rng)
    );

    always #5 clk = ~clk;

    // Stand-in stage: mode 1 converges immediately, mode 2 never converges, mode 0 mixes.
    function automatic logic [23:0] stage_fn(input int mode, input logic [7:0] a, b, xi);
        logic [7:0] c, d, xn;
        case (mode)
            1: begin c = 8'h38; d = 8'h40; xn = xi; end
            2: begin c = 8'h10; d = xi ^ 8'h5A; xn = xi + 8'h01; end
            default: begin
                c  = (xi[2:0] == 3'b101) ? 8'h36 : (b + xi);
                d  = a + xi;
                xn = xi + {5'b00000, a[2:0]} + 8'h01;
            end
        endcase
        return {c, d, xn};
    endfunction

    always_comb {it_c, it_d, it_xinew} = stage_fn(stage_mode, it_a, it_b, it_xi);

    typedef struct {
        logic [7:0] q;
        logic [2:0] iters;
        logic       cvg, dz, rng;
        int         lat;
        logic       touch;
        logic [7:0] ita, itb, itxi;
    } res_t;

    typedef struct {
        logic [7:0] a, b;
        int         mode;
        logic [7:0] q;
        logic [2:0] iters;
        logic       cvg, dz, rng;
        int         lat;
        int         hold;
    } vec_t;

    function automatic logic [3:0] seed_of(input logic [3:0] e);
        case (e)
            4'd7: return 4'd7;
            4'd8: return 4'd6;
            4'd9: return 4'd5;
            4'd10: return 4'd4;
            4'd6: return 4'd8;
            4'd5: return 4'd9;
            4'd4: return 4'd10;
            default: return 4'd0;
        endcase
    endfunction

    function automatic bit in_cvg_set(input logic [7:0] c);
        return (c == 8'h38) || (c == 8'h37) || (c == 8'h36) || (c == 8'h34);
    endfunction

    function automatic res_t model(input int mode, input logic [7:0] a, b);
        res_t r;
        logic [7:0] xi, c, d, xn;
        logic [3:0] s;
        bit fin;
        r = '{q: 8'h00, iters: 3'd0, cvg: 1'b0, dz: 1'b0, rng: 1'b0, lat: 1,
              touch: 1'b0, ita: 8'h00, itb: 8'h00, itxi: 8'h00};
        s = seed_of(b[6:3]);
        if (b == 8'h00) begin
            r.q = {a[7] ^ b[7], 7'h7F};
            r.dz = 1'b1;
        end else if (a == 8'h00) begin
            r.q = 8'h00;
        end else if (s == 4'd0) begin
            r.rng = 1'b1;
        end else begin
            r.touch = 1'b1; r.ita = a; r.itb = b;
            xi = {1'b0, s, 3'b000};
            fin = 1'b0;
            for (int k = 1; k <= MAXI; k++) begin
                if (!fin) begin
                    {c, d, xn} = stage_fn(mode, a, b, xi);
                    if ((EARLY && in_cvg_set(c)) || k == MAXI) begin
                        r.q = d; r.iters = 3'(k); r.cvg = in_cvg_set(c);
                        r.lat = k + 1; r.itxi = xi; fin = 1'b1;
                    end else begin
                        xi = xn;
                    end
                end
            end
        end
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic check_results(input string nm, input res_t e);
        chk({nm, "_q"}, out_q, e.q);
        chk({nm, "_iters"}, out_iters, e.iters);
        chk({nm, "_cvg"}, out_cvg, e.cvg);
        chk({nm, "_dz"}, out_dz, e.dz);
        chk({nm, "_rng"}, out_rng, e.rng);
    endtask

    task automatic apply(input string nm, input logic [7:0] a, b, input int mode,
                         input res_t e, input int hold);
        int wc, lat;
        stage_mode = mode;
        wc = 0;
        @(negedge clk);
        while (!in_ready && wc < 20) begin @(negedge clk); wc++; end
        chk({nm, "_in_ready"}, in_ready, 1'b1);
        in_a = a; in_b = b; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (out_valid) begin lat = i; break; end
        end
        chk({nm, "_latency"}, lat, e.lat);
        if (e.touch) begin g_ita = e.ita; g_itb = e.itb; g_itxi = e.itxi; end
        check_results(nm, e);
        chk({nm, "_it_a"}, it_a, g_ita);
        chk({nm, "_it_b"}, it_b, g_itb);
        chk({nm, "_it_xi"}, it_xi, g_itxi);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk({nm, "_hold_valid"}, out_valid, 1'b1);
            chk({nm, "_hold_in_ready"}, in_ready, 1'b0);
            check_results({nm, "_hold"}, e);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        chk({nm, "_post_valid"}, out_valid, 1'b0);
        chk({nm, "_post_in_ready"}, in_ready, 1'b1);
    endtask

    vec_t vecs[9];
    res_t e;

    initial begin
        vecs[0] = '{a: 8'h40, b: 8'h38, mode: 1, q: 8'h40, iters: (EARLY ? 3'd1 : 3'd3),
                    cvg: 1'b1, dz: 1'b0, rng: 1'b0, lat: (EARLY ? 2 : 4), hold: 0};
        vecs[1] = '{a: 8'hC0, b: 8'h00, mode: 0, q: 8'hFF, iters: 3'd0,
                    cvg: 1'b0, dz: 1'b1, rng: 1'b0, lat: 1, hold: 0};
        vecs[2] = '{a: 8'h00, b: 8'h40, mode: 0, q: 8'h00, iters: 3'd0,
                    cvg: 1'b0, dz: 1'b0, rng: 1'b0, lat: 1, hold: 1};
        vecs[3] = '{a: 8'h40, b: 8'h60, mode: 0, q: 8'h00, iters: 3'd0,
                    cvg: 1'b0, dz: 1'b0, rng: 1'b1, lat: 1, hold: 0};
        vecs[4] = '{a: 8'h40, b: 8'h40, mode: 2, q: 8'h68, iters: 3'd3,
                    cvg: 1'b0, dz: 1'b0, rng: 1'b0, lat: 4, hold: 5};
        vecs[5] = '{a: 8'h00, b: 8'h00, mode: 0, q: 8'h7F, iters: 3'd0,
                    cvg: 1'b0, dz: 1'b1, rng: 1'b0, lat: 1, hold: 0};
        vecs[6] = '{a: 8'h85, b: 8'h80, mode: 0, q: 8'h00, iters: 3'd0,
                    cvg: 1'b0, dz: 1'b0, rng: 1'b1, lat: 1, hold: 0};
        vecs[7] = '{a: 8'h00, b: 8'h60, mode: 0, q: 8'h00, iters: 3'd0,
                    cvg: 1'b0, dz: 1'b0, rng: 1'b0, lat: 1, hold: 0};
        vecs[8] = '{a: 8'hC1, b: 8'h38, mode: 2, q: 8'h60, iters: 3'd3,
                    cvg: 1'b0, dz: 1'b0, rng: 1'b0, lat: 4, hold: 2};

        // Reset state
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_q", out_q, 8'h00);
        chk("rst_out_flags", {out_iters, out_cvg, out_dz, out_rng}, 6'd0);
        chk("rst_it", {it_a, it_b, it_xi}, 24'd0);

        // Directed table
        foreach (vecs[i]) begin
            e = model(vecs[i].mode, vecs[i].a, vecs[i].b);
            e.q = vecs[i].q; e.iters = vecs[i].iters; e.cvg = vecs[i].cvg;
            e.dz = vecs[i].dz; e.rng = vecs[i].rng; e.lat = vecs[i].lat;
            apply($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].mode, e, vecs[i].hold);
        end

        // Budget sequence: xi follows xinew each evaluation, result after 3 evaluations
        stage_mode = 2;
        @(negedge clk);
        in_a = 8'h40; in_b = 8'h40; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("budget_xi%0d", k), it_xi, 8'h30 + 8'(k));
            chk($sformatf("budget_busy%0d", k), {out_valid, in_ready}, 2'b00);
        end
        @(negedge clk);
        chk("budget_valid", out_valid, 1'b1);
        chk("budget_result", {out_q, out_iters, out_cvg}, {8'h68, 3'd3, 1'b0});
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        g_ita = 8'h40; g_itb = 8'h40; g_itxi = 8'h32;

        // Reset during the second evaluation
        @(negedge clk);
        in_a = 8'h40; in_b = 8'h40; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("midrst_xi", it_xi, 8'h31);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("midrst_valid", out_valid, 1'b0);
        chk("midrst_in_ready", in_ready, 1'b1);
        chk("midrst_outs", {out_q, out_iters, out_cvg, out_dz, out_rng}, 14'd0);
        chk("midrst_it", {it_a, it_b, it_xi}, 24'd0);
        g_ita = 8'h00; g_itb = 8'h00; g_itxi = 8'h00;
        e = model(2, 8'hC1, 8'h38);
        apply("after_rst", 8'hC1, 8'h38, 2, e, 0);

        // Randomized operations against the reference model
        for (int n = 0; n < 60; n++) begin
            logic [7:0] ra, rb;
            int m;
            ra = 8'($urandom);
            rb = 8'($urandom);
            if ($urandom_range(0, 7) == 0) rb = 8'h00;
            else if ($urandom_range(0, 3) != 0) rb[6:3] = 4'($urandom_range(4, 10));
            if ($urandom_range(0, 9) == 0) ra = 8'h00;
            m = $urandom_range(0, 2);
            e = model(m, ra, rb);
            apply($sformatf("rnd%0d", n), ra, rb, m, e, $urandom_range(0, 3));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gs_iter_seq.md
Name: gs_iter_seq

Overview:
- Sequential controller for the 8-bit minifloat Goldschmidt divider.
- Accepts a dividend/divisor pair over a valid/ready handshake and looks up the ROM seed for the reciprocal factor.
- Drives the existing combinational iteration stage (inputs A, B, xi; outputs C = B*xi, D = A*xi, xinew) once per cycle. Feeds xinew back until the denominator converges to about 1.0 or the iteration budget runs out, then presents the quotient.
- Sits between the operand source and the iteration stage, replacing the unrolled three-stage chain with one reused stage.

Parameters:
- MAX_ITER, 3: maximum iteration-stage evaluations per division; legal range 1..7.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept operands.
- in_a  in  8  dividend; format {sign[7], exp[6:3] bias 7, frac[2:0] with hidden 1}.
- in_b  in  8  divisor, same format.
- it_a  out  8  to iteration stage A (latched dividend).
- it_b  out  8  to iteration stage B (latched divisor).
- it_xi  out  8  to iteration stage xi (current factor).
- it_c  in  8  from stage: new denominator.
- it_d  in  8  from stage: new numerator.
- it_xinew  in  8  from stage: next factor.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_q  out  8  quotient.
- out_iters  out  3  iteration-stage evaluations used (0 for special cases).
- out_cvg  out  1  exit was caused by convergence.
- out_dz  out  1  divide by zero.
- out_rng  out  1  divisor exponent outside the seed table.

Behaviour:
- Reset: state IDLE. in_ready=1; out_valid=0. All out_* and it_* registers = 0; iteration count = 0.
- FSM states: IDLE, ITER, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready (cycle T), latch a<=in_a and b<=in_b.
  - in_b==8'h00: out_q<={in_a[7]^in_b[7],7'h7F}, out_dz=1, out_iters=0, go to DONE. out_valid=1 at T+1.
  - else in_a==8'h00: out_q=8'h00, out_dz=0, go to DONE at T+1.
  - else seed exponent==4'b0000: out_q=8'h00, out_rng=1, go to DONE at T+1.
  - else xi<={1'b0, seed_exp, 3'b000}, count<=0, go to ITER.
- Seed table (b[6:3] -> seed_exp): 0111->0111, 1000->0110, 1001->0101, 1010->0100, 0110->1000, 0101->1001, 0100->1010; all others ->0000.
- Special-case priority: dz over zero-dividend over rng.
- ITER: it_a=a, it_b=b and it_xi=xi are driven from registers; the stage responds combinationally within the cycle. Each ITER cycle, sample it_c/it_d/it_xinew and set count+1.
  - Converged when it_c is one of {8'h38, 8'h37, 8'h36, 8'h34}.
  - If converged or count+1==MAX_ITER: out_q<=it_d, out_iters<=count+1, out_cvg<=converged, go to DONE.
  - Else xi<=it_xinew and stay in ITER.
- Latency: k evaluations give out_valid at T+k+1.
- DONE: out_valid=1; all out_* held stable until out_valid&&out_ready, then return to IDLE (in_ready=1 next cycle). in_ready=0 in ITER and DONE; a new pair cannot be accepted in the same cycle a result is consumed.
- it_* hold their last values outside ITER.
- Reset in any state: IDLE next cycle, any pending result discarded, all outputs back to reset values.
- Status flags (out_dz, out_rng, out_cvg) are cleared on every accept.

Optional Feature:
- GS_EARLY_EXIT_EN
  - Defined: convergence exit as above.
  - Undefined: the convergence test is removed; every non-special division runs exactly MAX_ITER evaluations, and out_cvg reports whether the final it_c matched the convergence set.

Decomposition:
- Shared package gs_pkg holds:
  - field-slice constants (SIGN_BIT=7, EXP_MSB=6, EXP_LSB=3, FRAC_W=3);
  - ONE_VAL=8'h38, MAX_FRAC_VAL=7'h7F;
  - the four convergence constants;
  - FSM state enum.
- One sub-module, gs_seed_rom: 4-bit exponent in, 4-bit seed out, purely combinational.

Test Plan:
- Fast convergence: stage model returns it_c=8'h38, it_d=8'h40 on the first evaluation. Send A=8'h40, B=8'h38 -> it_xi=8'h38, out_q=8'h40, out_iters=1, out_cvg=1, out_valid at T+2.
- Divide by zero: A=8'hC0, B=8'h00 -> out_q=8'hFF, out_dz=1, out_iters=0, out_valid at T+1, it_* unchanged.
- Zero dividend / range error:
  - A=8'h00, B=8'h40 -> out_q=8'h00 at T+1.
  - A=8'h40, B=8'h60 (exp 1100) -> out_rng=1, out_q=8'h00.
- Iteration budget: stage model never returns a convergence value -> exactly 3 evaluations, xi follows it_xinew each cycle, out_iters=3, out_cvg=0, out_valid at T+4. Same result with GS_EARLY_EXIT_EN undefined.
- Backpressure: out_ready=0 for 5 cycles after out_valid -> out_* stable, in_ready=0 throughout. out_ready=1 -> IDLE and in_ready=1 on the next cycle.
- Reset mid-ITER: rst high during the second evaluation -> next cycle IDLE, out_valid=0, in_ready=1, all outputs 0. Next operand pair processes normally.
